wb_stage_cp0x: RTL and testbench

- Parametrised successor to the current writeback stage: final pipeline stage with a built-in CP0 subset.
- Registers the memory-stage result and writes the register file.
- Commits exceptions and ERET, and computes the redirect PC and a one-cycle flush pulse for all earlier stages.
- Adds a Count/Compare timer and masked interrupt-pending detection, which are absent from the previous generation.

---
 rtl/wb_stage_cp0x.sv | 265 ++++++++++++++++++++++++++
 tb/tb_wb_stage_cp0x.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_cp0x.sv
// wb_stage_cp0x: final pipeline stage. Writes the GPR file, commits exceptions/ERET,
// and holds a CP0 subset (Status, Cause, EPC, BadVAddr, optional Count/Compare).
// Optional feature macro: CP0_TIMER_EN builds the Count/Compare timer and tick divider.
module wb_stage_cp0x #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned INT_NUM   = 6,
  parameter int unsigned COUNT_DIV = 2,
  parameter logic [31:0] EX_VEC    = 32'hBFC0_0380
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ws_allowin,
  input  logic              ms_to_ws_valid,
  input  logic [31:0]       ms_pc,
  input  logic              ms_gr_we,
  input  logic [ADDR_W-1:0] ms_dest,
  input  logic [31:0]       ms_result,
  input  logic              ms_ex,
  input  logic              ms_bd,
  input  logic [4:0]        ms_excode,
  input  logic [31:0]       ms_badvaddr,
  input  logic              ms_eret,
  input  logic              ms_mfc0,
  input  logic              ms_mtc0,
  input  logic [7:0]        ms_cp0_addr,
  input  logic [INT_NUM-1:0] ext_int_in,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              ws_flush,
  output logic [31:0]       ws_flush_pc,
  output logic              ws_int_pending,
  output logic [ADDR_W-1:0] ws_mfc0_dest,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
);

  // CP0 addresses as {rd, sel}
  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;
  localparam logic [4:0] EXC_ADEL     = 5'h04;
  localparam logic [4:0] EXC_ADES     = 5'h05;

  // Reject configurations the Cause.IP mapping and divider cannot represent
  if (COUNT_DIV < 1 || INT_NUM < 1 || INT_NUM > 6) begin : g_param_check
    $error("wb_stage_cp0x: unsupported INT_NUM or COUNT_DIV");
  end

  typedef struct packed {
    logic [31:0]       pc;
    logic              gr_we;
    logic [ADDR_W-1:0] dest;
    logic [31:0]       result;
    logic              ex;
    logic              bd;
    logic [4:0]        excode;
    logic [31:0]       badvaddr;
    logic              eret;
    logic              mfc0;
    logic              mtc0;
    logic [7:0]        cp0_addr;
  } ws_inst_t;

  logic        ws_valid_q, ws_valid_d;
  ws_inst_t    inst_q, inst_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        ws_ready_go;
  logic        commit_ex, commit_eret, cp0_we;
  logic        ti;
  logic [31:0] count_rd, compare_rd, status_rd, cause_rd, cp0_rdata;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = ~ws_valid_q | ws_ready_go;
  assign commit_ex   = ws_valid_q & inst_q.ex;
  assign commit_eret = ws_valid_q & inst_q.eret & ~inst_q.ex;
  assign cp0_we      = ws_valid_q & inst_q.mtc0 & ~inst_q.ex;

  assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti, 14'b0, ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q,
                      1'b0, exccode_q, 2'b0};

  // Combinational CP0 read port; unimplemented addresses read zero
  always_comb begin
    cp0_rdata = 32'h0;
    case (inst_q.cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = count_rd;
      CP0_COMPARE:  cp0_rdata = compare_rd;
      CP0_STATUS:   cp0_rdata = status_rd;
      CP0_CAUSE:    cp0_rdata = cause_rd;
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = 32'h0;
    endcase
  end

  // Stage capture and CP0 commit; exception beats ERET beats MTC0 on Status.EXL
  always_comb begin
    ws_valid_d = ws_valid_q;
    inst_d     = inst_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = 6'(ext_int_in);
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (ws_allowin) ws_valid_d = ms_to_ws_valid;
    if (ms_to_ws_valid && ws_allowin) begin
      inst_d.pc       = ms_pc;
      inst_d.gr_we    = ms_gr_we;
      inst_d.dest     = ms_dest;
      inst_d.result   = ms_result;
      inst_d.ex       = ms_ex;
      inst_d.bd       = ms_bd;
      inst_d.excode   = ms_excode;
      inst_d.badvaddr = ms_badvaddr;
      inst_d.eret     = ms_eret;
      inst_d.mfc0     = ms_mfc0;
      inst_d.mtc0     = ms_mtc0;
      inst_d.cp0_addr = ms_cp0_addr;
    end

    if (cp0_we) begin
      case (inst_q.cp0_addr)
        CP0_STATUS: begin
          im_d  = inst_q.result[15:8];
          exl_d = inst_q.result[1];
          ie_d  = inst_q.result[0];
        end
        CP0_CAUSE: ip_sw_d = inst_q.result[9:8];
        CP0_EPC:   epc_d   = inst_q.result;
        default: ;
      endcase
    end

    if (commit_eret) exl_d = 1'b0;

    if (commit_ex) begin
      exl_d     = 1'b1;
      exccode_d = inst_q.excode;
      if (!exl_q) begin
        bd_d  = inst_q.bd;
        epc_d = inst_q.bd ? inst_q.pc - 32'd4 : inst_q.pc;
      end
      if (inst_q.excode == EXC_ADEL || inst_q.excode == EXC_ADES)
        badvaddr_d = inst_q.badvaddr;
    end
  end

  // Stage and CP0 state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      inst_q     <= '0;
      im_q       <= 8'h0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= 5'h0;
      ip_sw_q    <= 2'h0;
      ip_hw_q    <= 6'h0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
    end else begin
      ws_valid_q <= ws_valid_d;
      inst_q     <= inst_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

`ifdef CP0_TIMER_EN
  localparam int unsigned    DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;

  // Count/Compare timer; software writes win over the divider and the TI set
  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (cp0_we && inst_q.cp0_addr == CP0_COUNT) begin
      count_d = inst_q.result;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (count_q == compare_q) ti_d = 1'b1;
    if (cp0_we && inst_q.cp0_addr == CP0_COMPARE) begin
      compare_d = inst_q.result;
      ti_d      = 1'b0;
    end
  end

  // Timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = 32'h0;
  assign compare_rd = 32'h0;
`endif

  assign rf_we          = ws_valid_q & inst_q.gr_we & ~inst_q.ex;
  assign rf_waddr       = inst_q.dest;
  assign rf_wdata       = inst_q.mfc0 ? cp0_rdata : inst_q.result;
  assign ws_flush       = commit_ex | (ws_valid_q & inst_q.eret);
  assign ws_flush_pc    = commit_ex ? EX_VEC : epc_q;
  assign ws_int_pending = ie_q & ~exl_q & |(cause_rd[15:8] & im_q);
  assign ws_mfc0_dest   = (ws_valid_q & inst_q.mfc0) ? inst_q.dest : '0;

  assign debug_wb_pc       = inst_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage_cp0x.sv
// tb_wb_stage_cp0x: directed scenarios plus random traffic against a CP0 reference model.
module tb_wb_stage_cp0x;

  localparam int unsigned COUNT_DIV = 2;
  localparam logic [31:0] EX_VEC    = 32'hBFC0_0380;
  localparam logic [7:0]  A_BADV = 8'h40, A_COUNT = 8'h48, A_CMP = 8'h58;
  localparam logic [7:0]  A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ex;
    logic        bd;
    logic [4:0]  excode;
    logic [31:0] badv;
    logic        eret;
    logic        mfc0;
    logic        mtc0;
    logic [7:0]  addr;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  instr_t      cur;
  logic [5:0]  ext_int;

  logic        ws_allowin, rf_we, ws_flush, ws_int_pending;
  logic [4:0]  rf_waddr, ws_mfc0_dest, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  instr_t      w;
  logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
  logic [4:0]  m_exc;
  logic        m_bd, m_ti;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_ext;
  int          m_div;

  always #5 clk = ~clk;

  wb_stage_cp0x #(.ADDR_W(5), .INT_NUM(6), .COUNT_DIV(COUNT_DIV), .EX_VEC(EX_VEC)) dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(cur.valid), .ms_pc(cur.pc), .ms_gr_we(cur.gr_we), .ms_dest(cur.dest),
    .ms_result(cur.result), .ms_ex(cur.ex), .ms_bd(cur.bd), .ms_excode(cur.excode),
    .ms_badvaddr(cur.badv), .ms_eret(cur.eret), .ms_mfc0(cur.mfc0), .ms_mtc0(cur.mtc0),
    .ms_cp0_addr(cur.addr), .ext_int_in(ext_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc), .ws_int_pending(ws_int_pending),
    .ws_mfc0_dest(ws_mfc0_dest), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c        = 32'h0;
    c[31]    = m_bd;
    c[30]    = m_ti;
    c[14:10] = m_ext[4:0];
    c[15]    = m_ext[5] | m_ti;
    c[9:8]   = m_ipsw;
    c[6:2]   = m_exc;
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_BADV:   return m_badv;
      A_COUNT:  return m_count;
      A_CMP:    return m_compare;
      A_STATUS: return m_status;
      A_CAUSE:  return m_cause();
      A_EPC:    return m_epc;
      default:  return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge
  task automatic model_edge();
    logic ex, er, we, old_exl, hit;
    if (reset) begin
      w = '0; m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
      m_exc = 0; m_bd = 0; m_ti = 0; m_ipsw = 0; m_ext = 0; m_div = 0;
      return;
    end
    ex      = w.valid && w.ex;
    er      = w.valid && w.eret && !w.ex;
    we      = w.valid && w.mtc0 && !w.ex;
    old_exl = m_status[1];
    hit     = (m_count == m_compare);
`ifdef CP0_TIMER_EN
    if (we && w.addr == A_COUNT) begin
      m_count = w.result; m_div = 0;
    end else begin
      m_div++;
      if (m_div == COUNT_DIV) begin m_div = 0; m_count = m_count + 1; end
    end
    if (we && w.addr == A_CMP) begin m_compare = w.result; m_ti = 0; end
    else if (hit) m_ti = 1;
`endif
    if (we && w.addr == A_STATUS)
      m_status = (m_status & ~32'h0000_FF03) | (w.result & 32'h0000_FF03);
    if (we && w.addr == A_CAUSE) m_ipsw = w.result[9:8];
    if (we && w.addr == A_EPC)   m_epc = w.result;
    if (er) m_status[1] = 1'b0;
    if (ex) begin
      m_status[1] = 1'b1;
      m_exc = w.excode;
      if (!old_exl) begin
        m_bd  = w.bd;
        m_epc = w.bd ? w.pc - 32'd4 : w.pc;
      end
      if (w.excode == 5'h04 || w.excode == 5'h05) m_badv = w.badv;
    end
    m_ext = ext_int;
    if (cur.valid) w = cur;
    else w.valid = 1'b0;
  endtask

  task automatic check_outputs();
    logic        exp_we, exp_fl;
    logic [31:0] exp_wd, c;
    exp_we = w.valid && w.gr_we && !w.ex;
    exp_wd = w.mfc0 ? m_read(w.addr) : w.result;
    exp_fl = w.valid && (w.ex || w.eret);
    c      = m_cause();
    check_eq("allowin",  32'(ws_allowin), 32'd1);
    check_eq("rf_we",    32'(rf_we), 32'(exp_we));
    check_eq("rf_waddr", 32'(rf_waddr), 32'(w.dest));
    check_eq("rf_wdata", rf_wdata, exp_wd);
    check_eq("flush",    32'(ws_flush), 32'(exp_fl));
    check_eq("flush_pc", ws_flush_pc, (w.valid && w.ex) ? EX_VEC : m_epc);
    check_eq("int_pend", 32'(ws_int_pending),
             32'(m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 0)));
    check_eq("mfc0_dest", 32'(ws_mfc0_dest), (w.valid && w.mfc0) ? 32'(w.dest) : 32'd0);
    check_eq("dbg_wen",  32'(debug_wb_rf_wen), exp_we ? 32'hF : 32'h0);
    check_eq("dbg_pc",   debug_wb_pc, w.pc);
    check_eq("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(w.dest));
    check_eq("dbg_wdata", debug_wb_rf_wdata, exp_wd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  // Present one instruction for one edge, then leave the input idle
  task automatic issue(input instr_t i);
    cur = i;
    tick();
    cur = '0;
  endtask

  function automatic instr_t mk_mtc0(input logic [7:0] a, input logic [31:0] d);
    instr_t i;
    i = '0; i.valid = 1; i.mtc0 = 1; i.addr = a; i.result = d; i.pc = 32'h8000_0100;
    return i;
  endfunction

  function automatic instr_t mk_mfc0(input logic [7:0] a);
    instr_t i;
    i = '0; i.valid = 1; i.mfc0 = 1; i.gr_we = 1; i.dest = 5'd3; i.addr = a; i.pc = 32'h8000_0200;
    return i;
  endfunction

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 6))
      0: return A_BADV;
      1: return A_COUNT;
      2: return A_CMP;
      3: return A_STATUS;
      4: return A_CAUSE;
      5: return A_EPC;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int     k;
    i        = '0;
    i.valid  = ($urandom_range(0, 9) < 7);
    i.pc     = $urandom & 32'hFFFF_FFFC;
    i.gr_we  = $urandom_range(0, 1) == 1;
    i.dest   = 5'($urandom);
    i.result = $urandom;
    i.bd     = $urandom_range(0, 1) == 1;
    i.ex     = ($urandom_range(0, 9) == 0);
    i.excode = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
    i.badv   = $urandom;
    i.addr   = pick_addr();
    k = $urandom_range(0, 9);
    if (k < 3) begin i.mfc0 = 1; i.gr_we = 1; end
    else if (k < 6) i.mtc0 = 1;
    else if (k == 6) i.eret = 1;
    if (i.mtc0 && i.addr == A_CMP && $urandom_range(0, 1) == 1)
      i.result = m_count + 32'($urandom_range(0, 6));
    return i;
  endfunction

  initial begin
    instr_t i;
    bit     seen;
    cur = '0; ext_int = '0; reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state of Status
    issue(mk_mfc0(A_STATUS));
    check_eq("status_rst", rf_wdata, 32'h0040_0000);

    // Plain GPR write
    i = '0; i.valid = 1; i.gr_we = 1; i.dest = 5'd7; i.result = 32'h1234_5678;
    issue(i);
    check_eq("gpr_we", 32'(rf_we), 32'd1);
    check_eq("gpr_waddr", 32'(rf_waddr), 32'd7);
    check_eq("gpr_wdata", rf_wdata, 32'h1234_5678);
    check_eq("gpr_wen", 32'(debug_wb_rf_wen), 32'hF);

    // Syscall in a delay slot
    i = '0; i.valid = 1; i.ex = 1; i.excode = 5'h08; i.bd = 1; i.pc = 32'h8000_1004; i.gr_we = 1;
    issue(i);
    check_eq("sys_flush", 32'(ws_flush), 32'd1);
    check_eq("sys_fpc", ws_flush_pc, 32'hBFC0_0380);
    check_eq("sys_rfwe", 32'(rf_we), 32'd0);
    issue(mk_mfc0(A_EPC));
    check_eq("sys_epc", rf_wdata, 32'h8000_1000);
    issue(mk_mfc0(A_CAUSE));
    check_eq("sys_bd", 32'(rf_wdata[31]), 32'd1);
    check_eq("sys_exc", 32'(rf_wdata[6:2]), 32'd8);
    issue(mk_mfc0(A_STATUS));
    check_eq("sys_exl", 32'(rf_wdata[1]), 32'd1);

    // ERET returns to EPC and drops EXL
    issue(mk_mtc0(A_EPC, 32'h8000_2000));
    i = '0; i.valid = 1; i.eret = 1; i.pc = 32'h8000_0300;
    issue(i);
    check_eq("eret_flush", 32'(ws_flush), 32'd1);
    check_eq("eret_fpc", ws_flush_pc, 32'h8000_2000);
    tick();
    issue(mk_mfc0(A_STATUS));
    check_eq("eret_exl", 32'(rf_wdata[1]), 32'd0);

    // MTC0 to Status carrying an exception: only EXL changes
    i = mk_mtc0(A_STATUS, 32'hFFFF_FFFF); i.ex = 1; i.excode = 5'h00; i.pc = 32'h8000_3000;
    issue(i);
    tick();
    issue(mk_mfc0(A_STATUS));
    check_eq("mtc0ex_status", rf_wdata, 32'h0040_0002);

    // Nested exception (EXL already set): EPC held, ExcCode and BadVAddr updated
    i = '0; i.valid = 1; i.ex = 1; i.excode = 5'h05; i.badv = 32'hDEAD_BEE0; i.pc = 32'h8000_4000;
    issue(i);
    check_eq("nest_fpc", ws_flush_pc, 32'hBFC0_0380);
    tick();
    issue(mk_mfc0(A_EPC));
    check_eq("nest_epc", rf_wdata, 32'h8000_3000);
    issue(mk_mfc0(A_CAUSE));
    check_eq("nest_exc", 32'(rf_wdata[6:2]), 32'd5);
    issue(mk_mfc0(A_BADV));
    check_eq("nest_badv", rf_wdata, 32'hDEAD_BEE0);
    i = '0; i.valid = 1; i.eret = 1;
    issue(i);

    // Timer interrupt: Count=0, Compare=10, enable IE with IM[7]
    issue(mk_mtc0(A_COUNT, 32'd0));
    issue(mk_mtc0(A_CMP, 32'd10));
    issue(mk_mtc0(A_STATUS, 32'h0000_8001));
`ifdef CP0_TIMER_EN
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick();
      if (ws_int_pending) seen = 1;
    end
    check_eq("tmr_pending", 32'(seen), 32'd1);
    issue(mk_mtc0(A_CMP, 32'd1000));
    tick();
    check_eq("tmr_clear", 32'(ws_int_pending), 32'd0);
    issue(mk_mfc0(A_CAUSE));
    check_eq("tmr_ti", 32'(rf_wdata[30]), 32'd0);
`else
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ws_int_pending) seen = 1;
    end
    check_eq("notmr_pending", 32'(seen), 32'd0);
    issue(mk_mfc0(A_COUNT));
    check_eq("notmr_count", rf_wdata, 32'd0);
`endif

    // Randomised traffic, interrupt lines and occasional reset mid-stream
    for (int n = 0; n < 3000; n++) begin
      cur   = rand_instr();
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
      tick();
    end
    reset = 1'b0;
    cur   = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
